load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDWIDTH, default 12, word-address width of the data memory.
REQ-002 SHALL have ports: clk in 1 clock; rst_n in 1 reset, asynchronous, active-low.
REQ-003 SHALL have: valid_i in 1 request from execute; ready_o out 1 unit idle/accepting.
REQ-004 SHALL have: is_load_i in 1; is_store_i in 1; funct3_i in 3 RV32I width/sign code.
REQ-005 SHALL have: addr_i in 32 byte effective address; wdata_i in 32 rs2 store data.
REQ-006 SHALL have: rdata_o out 32 extended load result; done_o out 1 completion pulse; err_o out 1 fault flag, valid with done_o.
REQ-007 SHALL have memory side: mem_address_o out ADDWIDTH word address; mem_data_o out 32; mem_str_o out 1; mem_ld_o out 1; mem_byte_masking_o out 4; mem_data_i in 32.

Function
REQ-008 SHALL implement states IDLE, ACCESS, WAIT, RESP; ready_o=1 only in IDLE.
REQ-009 SHALL accept a request when valid_i&&ready_o, registering all request fields at that edge.
REQ-010 SHALL flag a fault when: is_load_i==is_store_i; load funct3 in {011,110,111}; store funct3 not in {000,001,010}; halfword with addr[0]=1; word with addr[1:0]!=0.
REQ-011 Faulting request SHALL go IDLE->RESP, never assert mem_str_o/mem_ld_o, and leave rdata_o unchanged.
REQ-012 Valid request SHALL go IDLE->ACCESS; in ACCESS drive mem_address_o=addr[ADDWIDTH+1:2] and exactly one of mem_str_o/mem_ld_o for exactly one cycle.
REQ-013 Store SHALL go ACCESS->RESP; load SHALL go ACCESS->WAIT->RESP, capturing mem_data_i in WAIT (one-cycle memory read latency).
REQ-014 RESP SHALL pulse done_o for one cycle, err_o=fault, then return to IDLE; latency accept->done_o: store 2, load 3, fault 1 cycles.
REQ-015 Store mask: SB 4'b0001<<addr[1:0]; SH 4'b0011<<addr[1:0]; SW 4'b1111; loads drive mask 4'b1111.
REQ-016 Store data: SB {4{wdata[7:0]}}; SH {2{wdata[15:0]}}; SW wdata.
REQ-017 Load extract: lane = mem_data_i >> (8*addr[1:0]); LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
REQ-018 rdata_o SHALL be registered and hold its value until the next successful load completes.
REQ-019 Outside ACCESS, mem_str_o and mem_ld_o SHALL be 0; mem_address_o/mem_data_o hold last values.
REQ-020 valid_i while not ready_o SHALL be ignored (no queueing); requester holds it.
REQ-021 Address bits above ADDWIDTH+1 SHALL be ignored (wrap-around), no fault.

Reset
REQ-022 rst_n low SHALL immediately force IDLE, ready_o=1, done_o=0, err_o=0, mem_str_o=0, mem_ld_o=0, mem_byte_masking_o=0, mem_address_o=0, mem_data_o=0, rdata_o=0.
REQ-023 Reset mid-operation SHALL abort the access with no done_o pulse; memory write in flight is not guaranteed suppressed if its edge coincides with reset release.

Structure
REQ-024 Shared package SHALL hold the state enum and funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
REQ-025 Load extraction/extension SHALL be a combinational sub-module load_extend (inputs lane offset, funct3, word; output 32-bit).

Verification
REQ-026 SW addr 0x004 data 0x40110233 -> cycle after accept: mem_str_o=1, address 1, mask 1111, data 0x40110233; done_o 2 cycles after accept, err_o=0.
REQ-027 SB addr 0x006 data 0x000000AB -> mask 0100, mem_data_o 0xABABABAB.
REQ-028 Memory word 0x80F0_7F01 at address 1: LB 0x007 -> rdata_o 0xFFFFFF80; LBU 0x007 -> 0x00000080; LH 0x004 -> 0x00007F01; done_o 3 cycles after accept.
REQ-029 LW addr 0x005 -> done_o+err_o 1 cycle after accept, mem_ld_o never 1, rdata_o unchanged.
REQ-030 Assert rst_n=0 in WAIT of a load -> all outputs to reset values immediately, no done_o; next request completes normally.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Load/store unit shared types: FSM states, RV32I funct3 codes
// and the request decode helpers used at accept time.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_RESP
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic req_fault(
        input logic       ld,
        input logic       st,
        input logic [2:0] f3,
        input logic [1:0] off
    );
        logic bad_op;
        logic bad_align;
        bad_op = (ld == st);
        if (ld) begin
            bad_op = bad_op | (f3 inside {3'b011, 3'b110, 3'b111});
        end
        if (st) begin
            bad_op = bad_op | !(f3 inside {F3_B, F3_H, F3_W});
        end
        bad_align = ((f3 == F3_H || f3 == F3_HU) && off[0])
                  || (f3 == F3_W && off != 2'b00);
        return bad_op | bad_align;
    endfunction

    function automatic logic [3:0] store_mask(
        input logic [2:0] f3,
        input logic [1:0] off
    );
        case (f3)
            F3_B:    return 4'b0001 << off;
            F3_H:    return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(
        input logic [2:0]  f3,
        input logic [31:0] w
    );
        case (f3)
            F3_B:    return {4{w[7:0]}};
            F3_H:    return {2{w[15:0]}};
            default: return w;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Load lane extraction and sign/zero extension of a memory word.
module load_extend
    import load_store_unit_pkg::*;
(
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] word_i,
    output logic [31:0] data_o
);

    logic [31:0] lane;

    assign lane = word_i >> {off_i, 3'b000};

    always_comb begin
        data_o = lane;
        case (funct3_i)
            F3_B:    data_o = {{24{lane[7]}}, lane[7:0]};
            F3_H:    data_o = {{16{lane[15]}}, lane[15:0]};
            F3_BU:   data_o = {24'd0, lane[7:0]};
            F3_HU:   data_o = {16'd0, lane[15:0]};
            default: data_o = lane;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-request RV32I load/store unit in front of a word-addressed
// data memory with one-cycle read latency.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDWIDTH = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                valid_i,
    output logic                ready_o,
    input  logic                is_load_i,
    input  logic                is_store_i,
    input  logic [2:0]          funct3_i,
    input  logic [31:0]         addr_i,
    input  logic [31:0]         wdata_i,
    output logic [31:0]         rdata_o,
    output logic                done_o,
    output logic                err_o,
    output logic [ADDWIDTH-1:0] mem_address_o,
    output logic [31:0]         mem_data_o,
    output logic                mem_str_o,
    output logic                mem_ld_o,
    output logic [3:0]          mem_byte_masking_o,
    input  logic [31:0]         mem_data_i
);

    lsu_state_e          state_q, state_d;
    logic                load_q, load_d;
    logic [2:0]          f3_q, f3_d;
    logic [1:0]          off_q, off_d;
    logic                fault_q, fault_d;
    logic [ADDWIDTH-1:0] maddr_q, maddr_d;
    logic [31:0]         mdata_q, mdata_d;
    logic [3:0]          mask_q, mask_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [31:0]         ext;
    logic                fault_now;
    logic                unused_addr;

    // Upper address bits wrap around silently.
    assign unused_addr = ^addr_i[31:ADDWIDTH+2];

    assign fault_now = req_fault(is_load_i, is_store_i, funct3_i, addr_i[1:0]);

    load_extend u_load_extend (
        .off_i    (off_q),
        .funct3_i (f3_q),
        .word_i   (mem_data_i),
        .data_o   (ext)
    );

    always_comb begin
        state_d = state_q;
        load_d  = load_q;
        f3_d    = f3_q;
        off_d   = off_q;
        fault_d = fault_q;
        maddr_d = maddr_q;
        mdata_d = mdata_q;
        mask_d  = mask_q;
        rdata_d = rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (valid_i) begin
                    load_d  = is_load_i;
                    f3_d    = funct3_i;
                    off_d   = addr_i[1:0];
                    fault_d = fault_now;
                    if (fault_now) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_ACCESS;
                        maddr_d = addr_i[ADDWIDTH+1:2];
                        if (is_load_i) begin
                            mask_d = 4'b1111;
                        end else begin
                            mask_d  = store_mask(funct3_i, addr_i[1:0]);
                            mdata_d = store_data(funct3_i, wdata_i);
                        end
                    end
                end
            end
            S_ACCESS: state_d = load_q ? S_WAIT : S_RESP;
            S_WAIT: begin
                rdata_d = ext;
                state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            load_q  <= 1'b0;
            f3_q    <= 3'd0;
            off_q   <= 2'd0;
            fault_q <= 1'b0;
            maddr_q <= '0;
            mdata_q <= 32'd0;
            mask_q  <= 4'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            load_q  <= load_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            fault_q <= fault_d;
            maddr_q <= maddr_d;
            mdata_q <= mdata_d;
            mask_q  <= mask_d;
            rdata_q <= rdata_d;
        end
    end

    assign ready_o            = (state_q == S_IDLE);
    assign done_o             = (state_q == S_RESP);
    assign err_o              = (state_q == S_RESP) && fault_q;
    assign mem_str_o          = (state_q == S_ACCESS) && !load_q;
    assign mem_ld_o           = (state_q == S_ACCESS) && load_q;
    assign mem_address_o      = maddr_q;
    assign mem_data_o         = mdata_q;
    assign mem_byte_masking_o = mask_q;
    assign rdata_o            = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, reset-abort
// sequence and random traffic against a byte-level memory model.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic        is_load_i = 1'b0;
    logic        is_store_i = 1'b0;
    logic [2:0]  funct3_i = 3'd0;
    logic [31:0] addr_i = 32'd0;
    logic [31:0] wdata_i = 32'd0;
    logic [31:0] rdata_o;
    logic        done_o;
    logic        err_o;
    logic [11:0] mem_address_o;
    logic [31:0] mem_data_o;
    logic        mem_str_o;
    logic        mem_ld_o;
    logic [3:0]  mem_byte_masking_o;
    logic [31:0] mem_data_i;

    load_store_unit dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .valid_i            (valid_i),
        .ready_o            (ready_o),
        .is_load_i          (is_load_i),
        .is_store_i         (is_store_i),
        .funct3_i           (funct3_i),
        .addr_i             (addr_i),
        .wdata_i            (wdata_i),
        .rdata_o            (rdata_o),
        .done_o             (done_o),
        .err_o              (err_o),
        .mem_address_o      (mem_address_o),
        .mem_data_o         (mem_data_o),
        .mem_str_o          (mem_str_o),
        .mem_ld_o           (mem_ld_o),
        .mem_byte_masking_o (mem_byte_masking_o),
        .mem_data_i         (mem_data_i)
    );

    always #5 clk = ~clk;

    // Synchronous data memory, one-cycle read latency.
    logic [31:0] dmem [4096];
    logic [31:0] rdq = 32'd0;
    assign mem_data_i = rdq;

    always @(posedge clk) begin
        if (mem_str_o) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_byte_masking_o[i]) begin
                    dmem[mem_address_o][i*8 +: 8] <= mem_data_o[i*8 +: 8];
                end
            end
        end
        if (mem_ld_o) rdq <= dmem[mem_address_o];
    end

    // Reference model: flat byte memory plus last load result.
    logic [7:0]  rmem [16384];
    logic [31:0] last_rdata = 32'd0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int sz(input logic [2:0] f3);
        case (f3[1:0])
            2'd0:    return 1;
            2'd1:    return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit ref_fault(input logic ld, input logic st,
                                     input logic [2:0] f3,
                                     input logic [31:0] a);
        bit legal;
        if (ld == st) return 1'b1;
        if (ld) legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        else    legal = (f3 == 0 || f3 == 1 || f3 == 2);
        if (!legal) return 1'b1;
        return (int'(a[1:0]) % sz(f3)) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3,
                                             input logic [13:0] base);
        longint v;
        int     n;
        v = 0;
        n = sz(f3);
        for (int i = 0; i < n; i++) begin
            v += longint'(rmem[base + 14'(i)]) << (8 * i);
        end
        if (!f3[2] && n < 4 && v >= (longint'(1) << (8 * n - 1))) begin
            v -= longint'(1) << (8 * n);
        end
        return v[31:0];
    endfunction

    int          o_lat;
    logic        o_err;
    logic        o_done2;
    logic        o_busy;
    int          o_nst;
    int          o_nld;
    logic [11:0] o_maddr;
    logic [3:0]  o_mask;
    logic [31:0] o_mdata;
    logic [31:0] o_rdata;

    task automatic run_op(input logic ld, input logic st,
                          input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] w);
        int k;
        logic [13:0] base;
        @(negedge clk);
        k = 0;
        while (!ready_o && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!ready_o) chk("ready_wait", {31'd0, ready_o}, 32'd1);
        valid_i = 1'b1;
        is_load_i = ld;
        is_store_i = st;
        funct3_i = f3;
        addr_i = a;
        wdata_i = w;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        o_lat = 0; o_err = 1'b0; o_busy = 1'b0;
        o_nst = 0; o_nld = 0;
        o_maddr = 12'd0; o_mask = 4'd0; o_mdata = 32'd0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            if (ready_o) o_busy = 1'b1;
            if (mem_str_o) begin
                o_nst++;
                o_maddr = mem_address_o;
                o_mask = mem_byte_masking_o;
                o_mdata = mem_data_o;
            end
            if (mem_ld_o) begin
                o_nld++;
                o_maddr = mem_address_o;
                o_mask = mem_byte_masking_o;
            end
            if (done_o) begin
                o_lat = cyc;
                o_err = err_o;
                break;
            end
            @(posedge clk);
            #1;
        end
        o_rdata = rdata_o;
        @(posedge clk);
        #1;
        o_done2 = done_o;
        if (!ref_fault(ld, st, f3, a)) begin
            base = a[13:0];
            if (st) begin
                for (int i = 0; i < sz(f3); i++) begin
                    rmem[base + 14'(i)] = w[8*i +: 8];
                end
            end else begin
                last_rdata = ref_load(f3, base);
            end
        end
    endtask

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] w;
        int          lat;
        logic        err;
        logic [11:0] ma;
        logic [3:0]  mk;
        logic [31:0] md;
        logic [31:0] rd;
    } vec_t;

    function automatic vec_t mkv(logic ld, logic st, logic [2:0] f3,
                                 logic [31:0] a, logic [31:0] w, int lat,
                                 logic err, logic [11:0] ma, logic [3:0] mk,
                                 logic [31:0] md, logic [31:0] rd);
        vec_t v;
        v.ld = ld; v.st = st; v.f3 = f3; v.a = a; v.w = w;
        v.lat = lat; v.err = err; v.ma = ma; v.mk = mk;
        v.md = md; v.rd = rd;
        return v;
    endfunction

    vec_t tv[$];

    initial begin
        for (int i = 0; i < 4096; i++) dmem[i] = 32'd0;
        for (int i = 0; i < 16384; i++) rmem[i] = 8'd0;

        #2;
        chk("rst_ready", {31'd0, ready_o}, 32'd1);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_err", {31'd0, err_o}, 32'd0);
        chk("rst_str_ld", {30'd0, mem_str_o, mem_ld_o}, 32'd0);
        chk("rst_mask", {28'd0, mem_byte_masking_o}, 32'd0);
        chk("rst_addr", {20'd0, mem_address_o}, 32'd0);
        chk("rst_mdata", mem_data_o, 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        tv.push_back(mkv(0, 1, F3_W, 32'h004, 32'h40110233, 2, 0, 1, 4'hF, 32'h40110233, 32'h0));
        tv.push_back(mkv(0, 1, F3_B, 32'h006, 32'h000000AB, 2, 0, 1, 4'h4, 32'hABABABAB, 32'h0));
        tv.push_back(mkv(0, 1, F3_W, 32'h004, 32'h80F07F01, 2, 0, 1, 4'hF, 32'h80F07F01, 32'h0));
        tv.push_back(mkv(1, 0, F3_B, 32'h007, 32'h0, 3, 0, 1, 4'hF, 32'h0, 32'hFFFFFF80));
        tv.push_back(mkv(1, 0, F3_BU, 32'h007, 32'h0, 3, 0, 1, 4'hF, 32'h0, 32'h00000080));
        tv.push_back(mkv(1, 0, F3_H, 32'h004, 32'h0, 3, 0, 1, 4'hF, 32'h0, 32'h00007F01));
        tv.push_back(mkv(1, 0, F3_W, 32'h005, 32'h0, 1, 1, 0, 4'h0, 32'h0, 32'h00007F01));
        tv.push_back(mkv(1, 0, F3_HU, 32'h006, 32'h0, 3, 0, 1, 4'hF, 32'h0, 32'h000080F0));
        tv.push_back(mkv(1, 0, F3_H, 32'h006, 32'h0, 3, 0, 1, 4'hF, 32'h0, 32'hFFFF80F0));
        tv.push_back(mkv(0, 1, F3_H, 32'h00A, 32'h1234BEEF, 2, 0, 2, 4'hC, 32'hBEEFBEEF, 32'hFFFF80F0));
        tv.push_back(mkv(1, 0, F3_W, 32'h008, 32'h0, 3, 0, 2, 4'hF, 32'h0, 32'hBEEF0000));
        tv.push_back(mkv(1, 1, F3_W, 32'h000, 32'h0, 1, 1, 0, 4'h0, 32'h0, 32'hBEEF0000));
        tv.push_back(mkv(0, 0, F3_B, 32'h000, 32'h0, 1, 1, 0, 4'h0, 32'h0, 32'hBEEF0000));
        tv.push_back(mkv(1, 0, 3'b011, 32'h000, 32'h0, 1, 1, 0, 4'h0, 32'h0, 32'hBEEF0000));
        tv.push_back(mkv(0, 1, 3'b100, 32'h000, 32'h0, 1, 1, 0, 4'h0, 32'h0, 32'hBEEF0000));
        tv.push_back(mkv(0, 1, F3_H, 32'h001, 32'h0, 1, 1, 0, 4'h0, 32'h0, 32'hBEEF0000));
        tv.push_back(mkv(1, 0, F3_H, 32'h003, 32'h0, 1, 1, 0, 4'h0, 32'h0, 32'hBEEF0000));
        tv.push_back(mkv(1, 0, F3_W, 32'h00004004, 32'h0, 3, 0, 1, 4'hF, 32'h0, 32'h80F07F01));
        tv.push_back(mkv(0, 1, F3_W, 32'hFFFFC008, 32'h0BADF00D, 2, 0, 2, 4'hF, 32'h0BADF00D, 32'h80F07F01));
        tv.push_back(mkv(1, 0, F3_W, 32'h008, 32'h0, 3, 0, 2, 4'hF, 32'h0, 32'h0BADF00D));
        tv.push_back(mkv(1, 0, F3_B, 32'h009, 32'h0, 3, 0, 2, 4'hF, 32'h0, 32'hFFFFFFF0));

        foreach (tv[i]) begin
            run_op(tv[i].ld, tv[i].st, tv[i].f3, tv[i].a, tv[i].w);
            chk($sformatf("v%0d_lat", i), o_lat, tv[i].lat);
            chk($sformatf("v%0d_err", i), {31'd0, o_err}, {31'd0, tv[i].err});
            chk($sformatf("v%0d_done1", i), {31'd0, o_done2}, 32'd0);
            chk($sformatf("v%0d_busy", i), {31'd0, o_busy}, 32'd0);
            chk($sformatf("v%0d_nst", i), o_nst, (tv[i].st && !tv[i].err) ? 1 : 0);
            chk($sformatf("v%0d_nld", i), o_nld, (tv[i].ld && !tv[i].err) ? 1 : 0);
            if (!tv[i].err) begin
                chk($sformatf("v%0d_addr", i), {20'd0, o_maddr}, {20'd0, tv[i].ma});
                chk($sformatf("v%0d_mask", i), {28'd0, o_mask}, {28'd0, tv[i].mk});
                if (tv[i].st) chk($sformatf("v%0d_mdata", i), o_mdata, tv[i].md);
            end
            chk($sformatf("v%0d_rdata", i), o_rdata, tv[i].rd);
        end

        // Reset while a load sits in WAIT.
        @(negedge clk);
        valid_i = 1'b1; is_load_i = 1'b1; is_store_i = 1'b0;
        funct3_i = F3_B; addr_i = 32'h007;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        chk("abort_access_ld", {31'd0, mem_ld_o}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_ready", {31'd0, ready_o}, 32'd1);
        chk("abort_done", {31'd0, done_o}, 32'd0);
        chk("abort_err", {31'd0, err_o}, 32'd0);
        chk("abort_str_ld", {30'd0, mem_str_o, mem_ld_o}, 32'd0);
        chk("abort_mask", {28'd0, mem_byte_masking_o}, 32'd0);
        chk("abort_addr", {20'd0, mem_address_o}, 32'd0);
        chk("abort_mdata", mem_data_o, 32'd0);
        chk("abort_rdata", rdata_o, 32'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("abort_no_done", {31'd0, done_o}, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        last_rdata = 32'd0;
        run_op(1, 0, F3_W, 32'h004, 32'h0);
        chk("post_rst_lat", o_lat, 3);
        chk("post_rst_rdata", o_rdata, 32'h80F07F01);

        for (int t = 0; t < 300; t++) begin
            int          r;
            logic        ld, st, flt;
            logic [2:0]  f3;
            logic [31:0] a, w;
            logic [3:0]  emask;
            int          n;
            r = $urandom_range(0, 9);
            ld = (r < 4) || (r == 8);
            st = (r >= 4 && r < 8) || (r == 8);
            f3 = 3'($urandom_range(0, 7));
            a = (($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFFC000) : 32'd0)
              | 32'($urandom_range(0, 63));
            w = $urandom;
            flt = ref_fault(ld, st, f3, a);
            n = sz(f3);
            emask = 4'd0;
            for (int i = 0; i < 4; i++) begin
                emask[i] = ld || (i >= int'(a[1:0]) && i < int'(a[1:0]) + n);
            end
            run_op(ld, st, f3, a, w);
            chk("rnd_lat", o_lat, flt ? 1 : (st ? 2 : 3));
            chk("rnd_err", {31'd0, o_err}, {31'd0, flt});
            chk("rnd_done1", {31'd0, o_done2}, 32'd0);
            chk("rnd_nst", o_nst, (st && !flt) ? 1 : 0);
            chk("rnd_nld", o_nld, (ld && !flt) ? 1 : 0);
            if (!flt) begin
                chk("rnd_addr", {20'd0, o_maddr}, {20'd0, a[13:2]});
                chk("rnd_mask", {28'd0, o_mask}, {28'd0, emask});
                if (st) begin
                    for (int i = 0; i < 4; i++) begin
                        if (emask[i]) begin
                            chk("rnd_lane", {24'd0, o_mdata[8*i +: 8]},
                                {24'd0, w[8*(i - int'(a[1:0])) +: 8]});
                        end
                    end
                end
            end
            chk("rnd_rdata", o_rdata, last_rdata);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
